// File: rtl/mul_pkg.sv
// Shared types and sizing for the sequential signed shift-add multiplier.
package mul_pkg;

    localparam int unsigned MUL_WIDTH = 32;

    // Step counter width for the default operand width.
    localparam int unsigned MUL_CNT_W = $clog2(MUL_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mul_state_t;

    // Counter width for an arbitrary operand width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Bundle between the multiplier sequencer, its requester and the external add/sub unit.
interface mul_seq_ctrl_if #(
    parameter int unsigned WIDTH = 32
);

    logic                 start;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic [WIDTH:0]       adder_a;
    logic [WIDTH:0]       adder_b;
    logic                 adder_sub;
    logic                 adder_en;
    logic [WIDTH:0]       adder_s;
    logic                 adder_x;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;
    logic                 done;

    // System side: requester plus the add/sub unit.
    modport master (
        output start, multiplicand, multiplier,
        input  adder_a, adder_b, adder_sub, adder_en,
        output adder_s, adder_x,
        input  product, busy, done
    );

    // Sequencer side.
    modport slave (
        input  start, multiplicand, multiplier,
        output adder_a, adder_b, adder_sub, adder_en,
        input  adder_s, adder_x,
        output product, busy, done
    );

endinterface

// File: rtl/mul_ab_shreg.sv
// Accumulator A (WIDTH+1 bits) and multiplier B register pair: load, hold, or shift with sum.
module mul_ab_shreg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_b_init,
    input  logic [WIDTH:0]   i_sum,
    input  logic             i_sign,
    output logic [WIDTH:0]   o_a,
    output logic [WIDTH-1:0] o_b
);

    logic [WIDTH:0]   r_a;
    logic [WIDTH-1:0] r_b;

    // Load clears A and captures B; shift moves {sign, sum} right by one into {A, B}.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a <= '0;
            r_b <= '0;
        end else if (i_load) begin
            r_a <= '0;
            r_b <= i_b_init;
        end else if (i_shift) begin
            // The true sign keeps the shift exact when the WIDTH+1 sum overflowed.
            r_a <= {i_sign, i_sum[WIDTH:1]};
            r_b <= {i_sum[0], r_b[WIDTH-1:1]};
        end
    end

    assign o_a = r_a;
    assign o_b = r_b;

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequencer for the signed shift-add multiplier: one add/sub step per cycle, WIDTH steps.
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    mul_seq_ctrl_if.slave bus
);

    localparam int unsigned     CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    mul_state_t       r_state;
    mul_state_t       w_state_d;
    logic [CntW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_m;
    logic             w_load;
    logic             w_shift;
    logic             w_last;
    logic [WIDTH:0]   w_a;
    logic [WIDTH-1:0] w_b;

    assign w_last = (r_cnt == LastCnt);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next state and register-stage controls.
    always_comb begin
        w_state_d = r_state;
        w_load    = 1'b0;
        w_shift   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_load    = 1'b1;
                    w_state_d = RUN;
                end
            end
            RUN: begin
                w_shift = 1'b1;
                if (w_last) begin
                    w_state_d = DONE;
                end
            end
            DONE: begin
                // Start must fall before another multiply can be requested.
                if (!bus.start) begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // Step counter and latched multiplicand.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_m   <= '0;
        end else if (w_load) begin
            r_cnt <= '0;
            r_m   <= bus.multiplicand;
        end else if (w_shift) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    mul_ab_shreg #(
        .WIDTH (WIDTH)
    ) u_ab (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (w_load),
        .i_shift  (w_shift),
        .i_b_init (bus.multiplier),
        .i_sum    (bus.adder_s),
        .i_sign   (bus.adder_x),
        .o_a      (w_a),
        .o_b      (w_b)
    );

    // Adder drive; the last step subtracts because the multiplier MSB has negative weight.
    assign bus.adder_a   = w_a;
    assign bus.adder_b   = {r_m[WIDTH-1], r_m};
    assign bus.adder_en  = (r_state == RUN) & w_b[0];
    assign bus.adder_sub = (r_state == RUN) & w_b[0] & w_last;

    assign bus.product = {w_a[WIDTH-1:0], w_b};
    assign bus.busy    = (r_state == RUN);
    assign bus.done    = (r_state == DONE);

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl with a behavioural add/sub unit and a plain-multiply reference.
module tb_mul_seq_ctrl;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mul_seq_ctrl_if #(.WIDTH(W)) u_if ();

    mul_seq_ctrl #(
        .WIDTH (W)
    ) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (u_if.slave)
    );

    // Add/sub unit: exact WIDTH+2 bit result, low WIDTH+1 bits as sum, top bit as true sign.
    logic signed [W+1:0] add_full;
    always_comb begin
        add_full = $signed({u_if.adder_a[W], u_if.adder_a});
        if (u_if.adder_en) begin
            if (u_if.adder_sub) begin
                add_full = add_full - $signed({u_if.adder_b[W], u_if.adder_b});
            end else begin
                add_full = add_full + $signed({u_if.adder_b[W], u_if.adder_b});
            end
        end
    end
    assign u_if.adder_s = add_full[W:0];
    assign u_if.adder_x = add_full[W+1];

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
    endfunction

    // busy and done must never be seen together.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            n_cmp++;
            if ((u_if.busy & u_if.done) !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_done_excl: busy=%b done=%b required not both", u_if.busy,
                         u_if.done);
            end
        end
    end

    // Drives one multiply from a negedge; quirky drops start after load, scrambles operands
    // and pulses start mid-run. Returns at a negedge with the FSM back in IDLE.
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit quirky,
                           output logic [2*W-1:0] prod, output int cycles,
                           output int busy_cyc, output bit timeout);
        u_if.start        = 1'b1;
        u_if.multiplicand = a;
        u_if.multiplier   = b;
        cycles   = 0;
        busy_cyc = 0;
        timeout  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cycles++;
            if (u_if.busy === 1'b1) busy_cyc++;
            if (quirky) begin
                if (cycles == 1) begin
                    u_if.start        = 1'b0;
                    u_if.multiplicand = $urandom;
                    u_if.multiplier   = $urandom;
                end
                if (cycles == 12) u_if.start = 1'b1;
                if (cycles == 13) u_if.start = 1'b0;
            end
            if (u_if.done === 1'b1) begin
                timeout = 1'b0;
                break;
            end
        end
        prod       = u_if.product;
        u_if.start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n             = 1'b0;
        u_if.start        = 1'b0;
        u_if.multiplicand = '0;
        u_if.multiplier   = '0;
        #1;
        n_cmp++;
        if ({u_if.product, u_if.busy, u_if.done, u_if.adder_en, u_if.adder_sub} !== '0) begin
            n_fail++;
            $display("FAIL reset_asserted: product=%h busy=%b done=%b en=%b sub=%b required 0",
                     u_if.product, u_if.busy, u_if.done, u_if.adder_en, u_if.adder_sub);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({u_if.product, u_if.busy, u_if.done, u_if.adder_a} !== '0) begin
            n_fail++;
            $display("FAIL reset_release: product=%h busy=%b done=%b a=%h required 0",
                     u_if.product, u_if.busy, u_if.done, u_if.adder_a);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0]   va [5];
        logic [W-1:0]   vb [5];
        logic [2*W-1:0] ve [5];
        logic [2*W-1:0] prod;
        int             cyc;
        int             bcyc;
        bit             to;
        va[0] = 32'd7;          vb[0] = 32'hFFFF_FFFD; ve[0] = 64'hFFFF_FFFF_FFFF_FFEB;
        va[1] = 32'h8000_0000;  vb[1] = 32'h8000_0000; ve[1] = 64'h4000_0000_0000_0000;
        va[2] = 32'hFFFF_FFFF;  vb[2] = 32'hFFFF_FFFF; ve[2] = 64'h0000_0000_0000_0001;
        va[3] = 32'h1234_5678;  vb[3] = 32'h0;         ve[3] = 64'h0;
        va[4] = 32'h8000_0000;  vb[4] = 32'h7FFF_FFFF; ve[4] = 64'hC000_0000_8000_0000;
        for (int i = 0; i < 5; i++) begin
            run_mul(va[i], vb[i], 1'b0, prod, cyc, bcyc, to);
            n_cmp++;
            if (to || prod !== ve[i]) begin
                n_fail++;
                $display("FAIL directed_%0d: product=%h timeout=%b required %h", i, prod, to,
                         ve[i]);
            end
            n_cmp++;
            if (cyc != W + 1 || bcyc != W) begin
                n_fail++;
                $display("FAIL latency_%0d: done_edges=%0d busy=%0d required %0d/%0d", i, cyc,
                         bcyc, W + 1, W);
            end
            n_cmp++;
            if (u_if.busy !== 1'b0 || u_if.done !== 1'b0 || u_if.product !== ve[i]) begin
                n_fail++;
                $display("FAIL idle_retain_%0d: busy=%b done=%b product=%h required 0/0/%h",
                         i, u_if.busy, u_if.done, u_if.product, ve[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] prod;
        int             cyc;
        int             bcyc;
        bit             to;
        bit             quirky;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 6 == 1) a = 32'h8000_0000;
            if (i % 6 == 2) b = 32'h8000_0000;
            quirky = $urandom_range(0, 1);
            run_mul(a, b, quirky, prod, cyc, bcyc, to);
            n_cmp++;
            if (to || prod !== ref_mul(a, b) || cyc != W + 1) begin
                n_fail++;
                $display("FAIL random_%0d: %h*%h quirky=%b product=%h edges=%0d required %h/%0d",
                         i, a, b, quirky, prod, cyc, ref_mul(a, b), W + 1);
            end
        end
    endtask

    task automatic test_start_held();
        int             busy_cyc;
        int             done_rise;
        logic           prev_done;
        logic [2*W-1:0] exp;
        logic [2*W-1:0] held;
        bit             stable;
        exp               = ref_mul(32'hDEAD_BEEF, 32'h0BAD_F00D);
        u_if.multiplicand = 32'hDEAD_BEEF;
        u_if.multiplier   = 32'h0BAD_F00D;
        u_if.start        = 1'b1;
        busy_cyc  = 0;
        done_rise = 0;
        prev_done = 1'b0;
        stable    = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (u_if.busy === 1'b1) busy_cyc++;
            if (u_if.done === 1'b1 && prev_done === 1'b0) done_rise++;
            if (u_if.done === 1'b1 && u_if.product !== exp) stable = 1'b0;
            prev_done = u_if.done;
        end
        n_cmp++;
        if (busy_cyc != W || done_rise != 1 || u_if.done !== 1'b1) begin
            n_fail++;
            $display("FAIL start_held: busy=%0d done_rises=%0d done=%b required %0d/1/1",
                     busy_cyc, done_rise, u_if.done, W);
        end
        n_cmp++;
        if (!stable || u_if.product !== exp) begin
            n_fail++;
            $display("FAIL held_product: product=%h stable=%b required %h", u_if.product,
                     stable, exp);
        end
        u_if.start = 1'b0;
        held       = u_if.product;
        @(negedge clk);
        n_cmp++;
        if (u_if.done !== 1'b0 || u_if.busy !== 1'b0 || u_if.product !== held) begin
            n_fail++;
            $display("FAIL held_release: done=%b busy=%b product=%h required 0/0/%h",
                     u_if.done, u_if.busy, u_if.product, held);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [2*W-1:0] prod;
        int             cyc;
        int             bcyc;
        bit             to;
        u_if.multiplicand = 32'h7654_3210;
        u_if.multiplier   = 32'hFFFF_FFFF;
        u_if.start        = 1'b1;
        repeat (11) @(negedge clk);
        n_cmp++;
        if (u_if.busy !== 1'b1 || u_if.product === '0) begin
            n_fail++;
            $display("FAIL pre_reset_run: busy=%b product=%h required busy with nonzero data",
                     u_if.busy, u_if.product);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({u_if.product, u_if.busy, u_if.done, u_if.adder_a, u_if.adder_b,
             u_if.adder_en} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_run: product=%h busy=%b done=%b a=%h b=%h required 0",
                     u_if.product, u_if.busy, u_if.done, u_if.adder_a, u_if.adder_b);
        end
        u_if.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (u_if.busy !== 1'b0 || u_if.done !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: busy=%b done=%b required 0/0", u_if.busy,
                     u_if.done);
        end
        run_mul(32'd5, 32'd6, 1'b0, prod, cyc, bcyc, to);
        n_cmp++;
        if (to || prod !== 64'd30) begin
            n_fail++;
            $display("FAIL after_reset_mul: product=%h timeout=%b required %h", prod, to,
                     64'd30);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_held();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
